// File: rtl/col_scheduler_pkg.sv
// col_scheduler_pkg: constants and types shared by the column scheduler.
//   - state_e          : scheduler FSM state encoding
//   - HDR_LEN_LSB/W    : location of the beat-count field N in a header beat
//   - DEF_*            : default geometry used by the top and its interface
//   - bytes_per_beat() : byte size of one beat for a given beat width
package col_scheduler_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 128;
  localparam int unsigned DEF_COL_MAX_SIZE = 4;

  // Header beat: [HDR_LEN_LSB +: HDR_LEN_W] = N data beats; upper bits opaque.
  localparam int unsigned HDR_LEN_LSB = 0;
  localparam int unsigned HDR_LEN_W   = 16;

  function automatic int unsigned bytes_per_beat(input int unsigned data_width);
    return data_width / 8;
  endfunction

  localparam int unsigned BYTES_PER_BEAT = bytes_per_beat(DEF_DATA_WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StHdr,
    StXfer,
    StDone
  } state_e;

endpackage

// File: rtl/col_scheduler_if.sv
// col_scheduler_if: bundle between the scheduler, the per-column FWFT
// info/data FIFOs, the back FIFO and the partition/feedback control.
//   paritition_done : partition finished issuing column writes (pulse)
//   info_dout/empty : per-column header FIFO word and empty flag
//   info_rd_en      : header FIFO pop (one-hot or zero)
//   data_dout/empty : per-column data FIFO word and empty flag
//   data_rd_en      : data FIFO pop (one-hot or zero)
//   fifo_din/wr_en  : back FIFO write port; fifo_full its full flag
//   process_done    : one-cycle job completion pulse
//   data_len        : total bytes of the finished job
// Modports: master = scheduler side, slave = FIFO/environment side.
interface col_scheduler_if #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned COL_MAX_SIZE = 4
) ();

  logic                                 paritition_done;
  logic [COL_MAX_SIZE*DATA_WIDTH-1:0]   info_dout;
  logic [COL_MAX_SIZE-1:0]              info_empty;
  logic [COL_MAX_SIZE-1:0]              info_rd_en;
  logic [COL_MAX_SIZE*DATA_WIDTH-1:0]   data_dout;
  logic [COL_MAX_SIZE-1:0]              data_empty;
  logic [COL_MAX_SIZE-1:0]              data_rd_en;
  logic [DATA_WIDTH-1:0]                fifo_din;
  logic                                 fifo_wr_en;
  logic                                 fifo_full;
  logic                                 process_done;
  logic [31:0]                          data_len;

  modport master (
    input  paritition_done,
    input  info_dout,
    input  info_empty,
    output info_rd_en,
    input  data_dout,
    input  data_empty,
    output data_rd_en,
    output fifo_din,
    output fifo_wr_en,
    input  fifo_full,
    output process_done,
    output data_len
  );

  modport slave (
    output paritition_done,
    output info_dout,
    output info_empty,
    input  info_rd_en,
    output data_dout,
    output data_empty,
    input  data_rd_en,
    input  fifo_din,
    input  fifo_wr_en,
    output fifo_full,
    input  process_done,
    input  data_len
  );

endinterface

// File: rtl/col_scheduler_rr_arbiter.sv
// rr_arbiter: rotating-priority encoder. Grants the first requester found
// searching upward from i_ptr with wrap-around.
//   i_req   : request vector (one bit per column)
//   i_ptr   : highest-priority index for this search
//   o_grant : one-hot grant, zero when nothing requests
//   o_valid : a grant was issued
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [PtrW-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic            o_valid
);

  logic [PtrW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = PtrW'((32'(i_ptr) + i) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/col_scheduler.sv
// col_scheduler: drains per-column header/data FIFOs into the back FIFO,
// one packet (header + N data beats) per round-robin grant. After partition
// signals completion and all header FIFOs are empty, pulses process_done
// and reports the job's byte count on data_len.
//   user_clk : clock
//   user_rst : synchronous active-low reset
//   io_bus   : col_scheduler_if master modport (FIFO ports, done/len)
module col_scheduler
  import col_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned COL_MAX_SIZE = DEF_COL_MAX_SIZE,
  parameter int unsigned LEN_W        = HDR_LEN_W
) (
  input logic             user_clk,
  input logic             user_rst,
  col_scheduler_if.master io_bus
);

  localparam int unsigned PtrW      = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;
  localparam int unsigned BytesBeat = bytes_per_beat(DATA_WIDTH);

  state_e            r_state, w_state_nxt;
  logic [PtrW-1:0]   r_col, w_col_nxt;
  logic [PtrW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [LEN_W-1:0]  r_remain, w_remain_nxt;
  logic              r_done_seen;
  logic [31:0]       r_beat_cnt;
  logic [31:0]       r_data_len;

  logic [COL_MAX_SIZE-1:0] w_grant;
  logic                    w_grant_vld;
  logic [PtrW-1:0]         w_grant_idx;
  logic [DATA_WIDTH-1:0]   w_hdr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [LEN_W-1:0]        w_hdr_len;
  logic [PtrW-1:0]         w_col_inc;
  logic [31:0]             w_len_bytes;

  logic [COL_MAX_SIZE-1:0] w_info_rd_en;
  logic [COL_MAX_SIZE-1:0] w_data_rd_en;
  logic [DATA_WIDTH-1:0]   w_fifo_din;
  logic                    w_fifo_wr_en;
  logic                    w_process_done;

  rr_arbiter #(
    .N    (COL_MAX_SIZE),
    .PtrW (PtrW)
  ) u_rr_arbiter (
    .i_req   (~io_bus.info_empty),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_valid (w_grant_vld)
  );

  always_comb begin
    w_grant_idx = '0;
    for (int unsigned i = 0; i < COL_MAX_SIZE; i++) begin
      if (w_grant[i]) w_grant_idx = PtrW'(i);
    end
  end

  // FWFT: the head word of the granted column is always on dout.
  assign w_hdr       = io_bus.info_dout[32'(r_col)*DATA_WIDTH +: DATA_WIDTH];
  assign w_data      = io_bus.data_dout[32'(r_col)*DATA_WIDTH +: DATA_WIDTH];
  assign w_hdr_len   = w_hdr[HDR_LEN_LSB +: LEN_W];
  assign w_col_inc   = (32'(r_col) == COL_MAX_SIZE - 1) ? '0 : r_col + 1'b1;
  assign w_len_bytes = r_beat_cnt * 32'(BytesBeat);

  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_remain_nxt   = r_remain;
    w_info_rd_en   = '0;
    w_data_rd_en   = '0;
    w_fifo_din     = '0;
    w_fifo_wr_en   = 1'b0;
    w_process_done = 1'b0;

    unique case (r_state)
      StIdle: w_state_nxt = StArb;

      StArb: begin
        if (w_grant_vld) begin
          w_col_nxt   = w_grant_idx;
          w_state_nxt = StHdr;
        end else if (r_done_seen && (&io_bus.info_empty)) begin
          w_state_nxt = StDone;
        end
      end

      StHdr: begin
        if (!io_bus.fifo_full) begin
          w_info_rd_en[r_col] = 1'b1;
          w_fifo_wr_en        = 1'b1;
          w_fifo_din          = w_hdr;
          w_remain_nxt        = w_hdr_len;
          w_rr_ptr_nxt        = w_col_inc;
          w_state_nxt         = (w_hdr_len != '0) ? StXfer : StArb;
        end
      end

      StXfer: begin
        if (!io_bus.data_empty[r_col] && !io_bus.fifo_full) begin
          w_data_rd_en[r_col] = 1'b1;
          w_fifo_wr_en        = 1'b1;
          w_fifo_din          = w_data;
          w_remain_nxt        = r_remain - 1'b1;
          if (r_remain == LEN_W'(1)) w_state_nxt = StArb;
        end
      end

      StDone: begin
        w_process_done = 1'b1;
        w_state_nxt    = StIdle;
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst) begin
      r_state     <= StIdle;
      r_col       <= '0;
      r_rr_ptr    <= '0;
      r_remain    <= '0;
      r_done_seen <= 1'b0;
      r_beat_cnt  <= '0;
      r_data_len  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_col    <= w_col_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_remain <= w_remain_nxt;

      if (r_state == StDone) begin
        r_done_seen <= 1'b0;
      end else if (io_bus.paritition_done) begin
        r_done_seen <= 1'b1;
      end

      if (r_state == StDone) begin
        r_beat_cnt <= '0;
      end else if (w_fifo_wr_en) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
      end

      if (r_state == StDone) r_data_len <= w_len_bytes;
    end
  end

  assign io_bus.info_rd_en   = w_info_rd_en;
  assign io_bus.data_rd_en   = w_data_rd_en;
  assign io_bus.fifo_din     = w_fifo_din;
  assign io_bus.fifo_wr_en   = w_fifo_wr_en;
  assign io_bus.process_done = w_process_done;
  // Byte count is visible in the DONE cycle itself and held afterwards.
  assign io_bus.data_len     = (r_state == StDone) ? w_len_bytes : r_data_len;

endmodule

// File: tb/tb_col_scheduler.sv
module tb_col_scheduler;
  import col_scheduler_pkg::*;

  localparam int DW = 128;
  localparam int NC = 4;

  logic clk;
  logic rst_n;

  col_scheduler_if #(.DATA_WIDTH(DW), .COL_MAX_SIZE(NC)) bus ();

  col_scheduler dut (
    .user_clk (clk),
    .user_rst (rst_n),
    .io_bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] info_q [NC][$];
  logic [DW-1:0] data_q [NC][$];
  logic [DW-1:0] back_log [$];

  int checks = 0;
  int errors = 0;
  int done_cnt, done_log_size, full_viol, underflow;
  logic [31:0] done_len;
  int info_pops [NC];
  int data_pops [NC];

  function automatic logic [DW-1:0] mk_hdr(input int tag, input int n);
    return {32'hC0DE0000 + 32'(tag), 80'h0, 16'(n)};
  endfunction

  function automatic logic [DW-1:0] mk_data(input int tag);
    return {4{32'hDA7A0000 + 32'(tag)}};
  endfunction

  task automatic refresh();
    for (int c = 0; c < NC; c++) begin
      bus.info_empty[c]          = (info_q[c].size() == 0);
      bus.info_dout[c*DW +: DW]  = (info_q[c].size() == 0) ? '0 : info_q[c][0];
      bus.data_empty[c]          = (data_q[c].size() == 0);
      bus.data_dout[c*DW +: DW]  = (data_q[c].size() == 0) ? '0 : data_q[c][0];
    end
  endtask

  // Called at a falling edge: sample, model FIFO pops, cross a rising edge.
  task automatic tick();
    #1;
    if (bus.fifo_wr_en) back_log.push_back(bus.fifo_din);
    if (bus.fifo_full && (bus.fifo_wr_en || (|bus.info_rd_en) || (|bus.data_rd_en)))
      full_viol++;
    for (int c = 0; c < NC; c++) begin
      if (bus.info_rd_en[c]) begin
        info_pops[c]++;
        if (info_q[c].size() > 0) void'(info_q[c].pop_front());
        else underflow++;
      end
      if (bus.data_rd_en[c]) begin
        data_pops[c]++;
        if (data_q[c].size() > 0) void'(data_q[c].pop_front());
        else underflow++;
      end
    end
    if (bus.process_done) begin
      done_cnt++;
      done_len      = bus.data_len;
      done_log_size = back_log.size();
    end
    @(posedge clk);
    @(negedge clk);
    refresh();
  endtask

  task automatic clear_model();
    for (int c = 0; c < NC; c++) begin
      info_q[c].delete();
      data_q[c].delete();
      info_pops[c] = 0;
      data_pops[c] = 0;
    end
    back_log.delete();
    done_cnt      = 0;
    done_log_size = 0;
    done_len      = '0;
    full_viol     = 0;
    underflow     = 0;
  endtask

  task automatic reset_dut();
    rst_n                = 1'b0;
    bus.fifo_full        = 1'b0;
    bus.paritition_done  = 1'b0;
    tick();
    tick();
    clear_model();
    refresh();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_done();
    bus.paritition_done = 1'b1;
    tick();
    bus.paritition_done = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = done_cnt;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (done_cnt > start) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n               = 1'b0;
    bus.fifo_full       = 1'b0;
    bus.paritition_done = 1'b0;
    clear_model();
    refresh();
    tick();
    tick();
    #1;
    checks++;
    if (bus.fifo_wr_en !== 1'b0 || bus.info_rd_en !== '0 || bus.data_rd_en !== '0) begin
      errors++;
      $display("FAIL reset_strobes: got wr=%b info=%b data=%b expected 0", bus.fifo_wr_en,
               bus.info_rd_en, bus.data_rd_en);
    end
    checks++;
    if (bus.fifo_din !== '0 || bus.process_done !== 1'b0 || bus.data_len !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got din=%0h done=%b len=%0d expected 0", bus.fifo_din,
               bus.process_done, bus.data_len);
    end
    checks++;
    if (dut.r_state !== StIdle || dut.r_rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d ptr=%0d expected %0d/0", dut.r_state,
               dut.r_rr_ptr, StIdle);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (dut.r_state !== StArb) begin
      errors++;
      $display("FAIL reset_leave_idle: got state=%0d expected %0d", dut.r_state, StArb);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] exp [4];
    bit ok;
    exp[0] = mk_hdr(20, 3);
    exp[1] = mk_data(21);
    exp[2] = mk_data(22);
    exp[3] = mk_data(23);
    info_q[2].push_back(exp[0]);
    for (int i = 1; i < 4; i++) data_q[2].push_back(exp[i]);
    refresh();
    pulse_done();
    wait_done(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_done: got no process_done expected one within 40 cycles");
    end
    checks++;
    if (back_log.size() != 4) begin
      errors++;
      $display("FAIL single_count: got %0d writes expected 4", back_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (back_log[i] !== exp[i]) begin
          errors++;
          $display("FAIL single_beat%0d: got %0h expected %0h", i, back_log[i], exp[i]);
        end
      end
    end
    checks++;
    if (done_len !== 32'd64) begin
      errors++;
      $display("FAIL single_len: got %0d expected 64", done_len);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp [6];
    bit ok;
    reset_dut();
    exp[0] = mk_hdr(0, 1); exp[1] = mk_data(100);
    exp[2] = mk_hdr(1, 1); exp[3] = mk_data(101);
    exp[4] = mk_hdr(3, 1); exp[5] = mk_data(103);
    info_q[0].push_back(exp[0]); data_q[0].push_back(exp[1]);
    info_q[1].push_back(exp[2]); data_q[1].push_back(exp[3]);
    info_q[3].push_back(exp[4]); data_q[3].push_back(exp[5]);
    refresh();
    // Done pulse lands in the same cycle as the first grant.
    pulse_done();
    wait_done(60, ok);
    checks++;
    if (!ok || back_log.size() != 6) begin
      errors++;
      $display("FAIL rr_count: got done=%b writes=%0d expected 1/6", ok, back_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (back_log[i] !== exp[i]) begin
          errors++;
          $display("FAIL rr_order%0d: got %0h expected %0h", i, back_log[i], exp[i]);
        end
      end
    end
    checks++;
    if (dut.r_rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL rr_ptr_end: got %0d expected 0", dut.r_rr_ptr);
    end
    checks++;
    if (done_len !== 32'd96) begin
      errors++;
      $display("FAIL rr_len: got %0d expected 96", done_len);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    int n;
    reset_dut();
    info_q[1].push_back(mk_hdr(7, 0));
    data_q[1].push_back(mk_data(77));  // must stay untouched
    refresh();
    n = 0;
    while (back_log.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (back_log.size() != 1 || dut.r_state !== StArb) begin
      errors++;
      $display("FAIL zero_hdr: got writes=%0d state=%0d expected 1/%0d", back_log.size(),
               dut.r_state, StArb);
    end
    pulse_done();
    wait_done(20, ok);
    checks++;
    if (!ok || done_len !== 32'd16 || back_log.size() != 1) begin
      errors++;
      $display("FAIL zero_done: got done=%b len=%0d writes=%0d expected 1/16/1", ok, done_len,
               back_log.size());
    end
    checks++;
    if (data_pops[1] != 0 || data_q[1].size() != 1) begin
      errors++;
      $display("FAIL zero_no_data_pop: got pops=%0d expected 0", data_pops[1]);
    end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] exp [5];
    bit ok;
    int n;
    reset_dut();
    exp[0] = mk_hdr(40, 4);
    for (int i = 1; i < 5; i++) exp[i] = mk_data(40 + i);
    info_q[0].push_back(exp[0]);
    for (int i = 1; i < 5; i++) data_q[0].push_back(exp[i]);
    refresh();
    n = 0;
    while (back_log.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    bus.fifo_full = 1'b1;
    refresh();
    repeat (5) tick();
    checks++;
    if (back_log.size() != 2 || full_viol != 0 || data_q[0].size() != 3) begin
      errors++;
      $display("FAIL bp_stall: got writes=%0d viol=%0d left=%0d expected 2/0/3",
               back_log.size(), full_viol, data_q[0].size());
    end
    bus.fifo_full = 1'b0;
    refresh();
    pulse_done();
    wait_done(40, ok);
    checks++;
    if (!ok || back_log.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got done=%b writes=%0d expected 1/5", ok, back_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (back_log[i] !== exp[i]) begin
          errors++;
          $display("FAIL bp_beat%0d: got %0h expected %0h", i, back_log[i], exp[i]);
        end
      end
    end
    checks++;
    if (done_len !== 32'd80) begin
      errors++;
      $display("FAIL bp_len: got %0d expected 80", done_len);
    end
  endtask

  task automatic test_early_done();
    logic [DW-1:0] exp [5];
    bit ok;
    reset_dut();
    exp[0] = mk_hdr(50, 2); exp[1] = mk_data(51); exp[2] = mk_data(52);
    exp[3] = mk_hdr(53, 1); exp[4] = mk_data(54);
    info_q[0].push_back(exp[0]);
    info_q[0].push_back(exp[3]);
    data_q[0].push_back(exp[1]);
    data_q[0].push_back(exp[2]);
    refresh();
    pulse_done();
    // Second packet's data beat is withheld: packet in flight, info FIFOs empty.
    repeat (12) tick();
    checks++;
    if (done_cnt != 0 || back_log.size() != 4) begin
      errors++;
      $display("FAIL early_hold: got done=%0d writes=%0d expected 0/4", done_cnt,
               back_log.size());
    end
    data_q[0].push_back(exp[4]);
    refresh();
    wait_done(30, ok);
    checks++;
    if (!ok || done_log_size != 5 || done_len !== 32'd80) begin
      errors++;
      $display("FAIL early_done: got done=%b writes=%0d len=%0d expected 1/5/80", ok,
               done_log_size, done_len);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (back_log[i] !== exp[i]) begin
          errors++;
          $display("FAIL early_beat%0d: got %0h expected %0h", i, back_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    reset_dut();
    info_q[3].push_back(mk_hdr(60, 4));
    for (int i = 0; i < 4; i++) data_q[3].push_back(mk_data(61 + i));
    refresh();
    n = 0;
    while (back_log.size() < 3 && n < 20) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    tick();
    #1;
    checks++;
    if (bus.fifo_wr_en !== 1'b0 || bus.info_rd_en !== '0 || bus.data_rd_en !== '0 ||
        bus.fifo_din !== '0 || bus.process_done !== 1'b0 || bus.data_len !== 32'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got wr=%b info=%b data=%b din=%0h done=%b len=%0d expected 0",
               bus.fifo_wr_en, bus.info_rd_en, bus.data_rd_en, bus.fifo_din,
               bus.process_done, bus.data_len);
    end
    checks++;
    if (dut.r_state !== StIdle) begin
      errors++;
      $display("FAIL midrst_state: got %0d expected %0d", dut.r_state, StIdle);
    end
    clear_model();
    refresh();
    rst_n = 1'b1;
    tick();
    info_q[1].push_back(mk_hdr(70, 1));
    data_q[1].push_back(mk_data(71));
    refresh();
    pulse_done();
    wait_done(30, ok);
    checks++;
    if (!ok || done_len !== 32'd32 || back_log.size() != 2) begin
      errors++;
      $display("FAIL midrst_fresh_len: got done=%b len=%0d writes=%0d expected 1/32/2", ok,
               done_len, back_log.size());
    end
    checks++;
    if (underflow != 0) begin
      errors++;
      $display("FAIL pop_empty: got %0d pops of empty FIFOs expected 0", underflow);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.fifo_full       = 1'b0;
    bus.paritition_done = 1'b0;
    clear_model();
    refresh();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_back_pressure();
    test_early_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
